uart_frame_tx: RTL and testbench

//  Downstream stage of the keyboard/key-press block. Accepts pre-framed 10-bit serial words
//  {stop, ascii[7:0], start} over a valid/ready handshake and buffers them in a small FIFO.

---
 rtl/piano_uart_pkg.sv | 17 +
 rtl/uart_fifo.sv | 53 +++++
 rtl/uart_frame_tx.sv | 104 ++++++++++
 tb/tb_uart_frame_tx.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/piano_uart_pkg.sv
// Shared constants and types for the key-press -> UART transmit path.
package piano_uart_pkg;

    localparam int   FRAME_W   = 10;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic {
        IDLE,
        SHIFT
    } tx_state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous frame FIFO; pointers wrap naturally because DEPTH is a power of two.
module uart_fifo #(
    parameter int  WIDTH = 10,
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/uart_frame_tx.sv
// Buffers pre-framed words and shifts them out LSB-first on a UART TX line.
//   state | meaning
//   IDLE  | line high; loads the FIFO head into the shifter when one is queued
//   SHIFT | drives shreg[0], advancing one bit every CLKS_PER_BIT cycles
module uart_frame_tx #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 4,
    parameter int FRAME_W    = piano_uart_pkg::FRAME_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FRAME_W-1:0] inputData,
    input  logic               ivalid,
    output logic               iready,
    output logic               txd,
    output logic               busy,
    output logic               frame_err
);
    import piano_uart_pkg::*;

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(FRAME_W);
    localparam int FCNT_W       = $clog2(FIFO_DEPTH + 1);

    tx_state_t          state;
    logic [FRAME_W-1:0] shreg;
    logic [CNT_W-1:0]   baud_cnt;
    logic [IDX_W-1:0]   bit_idx;

    logic               xfer;
    logic               frame_ok;
    logic               push;
    logic               pop;
    logic [FRAME_W-1:0] fifo_dout;
    logic [FCNT_W-1:0]  fifo_count;
    logic               fifo_full;
    logic               fifo_empty;

    assign xfer     = ivalid && iready;
    assign frame_ok = (inputData[0] == START_BIT) && (inputData[FRAME_W-1] == STOP_BIT);
    assign push     = xfer && frame_ok;
    assign pop      = (state == IDLE) && !fifo_empty;

    // Full flag comes straight off the registered count, so no path from ivalid.
    assign iready   = !fifo_full;
    assign busy     = (state != IDLE) || (fifo_count != '0);

    uart_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (inputData),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            txd       <= 1'b1;
            frame_err <= 1'b0;
        end else begin
            frame_err <= xfer && !frame_ok;
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (!fifo_empty) begin
                        shreg    <= fifo_dout;
                        bit_idx  <= '0;
                        baud_cnt <= '0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    txd <= shreg[0];
                    if (baud_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        baud_cnt <= '0;
                        shreg    <= shreg >> 1;
                        if (bit_idx == IDX_W'(FRAME_W - 1)) begin
                            state <= IDLE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx at default parameters (434 clocks per bit).
module tb_uart_frame_tx;

    localparam int CPB = 434;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] inputData = '0;
    logic       ivalid = 1'b0;
    logic       iready;
    logic       txd;
    logic       busy;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    logic [9:0] fill_fr [5] = '{10'h286, 10'h2C2, 10'h284, 10'h2A0, 10'h2FE};

    uart_frame_tx dut (
        .clk       (clk),
        .reset     (reset),
        .inputData (inputData),
        .ivalid    (ivalid),
        .iready    (iready),
        .txd       (txd),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Samples every cycle of a frame from the current point; bit 0 may be partly consumed.
    task automatic expect_frame(input logic [9:0] f, input int skip, input string tag);
        int bad = 0;
        for (int i = 0; i < 10; i++) begin
            for (int c = (i == 0) ? skip : 0; c < CPB; c++) begin
                if (txd !== f[i]) bad++;
                tick();
            end
        end
        check(tag, bad, 0);
    endtask

    task automatic send(input logic [9:0] f);
        inputData = f;
        ivalid    = 1'b1;
        tick();
        ivalid    = 1'b0;
    endtask

    initial begin
        // 1: reset, including a reset in the middle of a frame
        tick(); tick(); tick();
        reset = 1'b0;
        check("rst0_txd", txd, 1);
        check("rst0_iready", iready, 1);
        check("rst0_busy", busy, 0);
        check("rst0_ferr", frame_err, 0);
        send(10'h286);
        repeat (300) tick();
        check("mid_busy", busy, 1);
        reset = 1'b1;
        tick(); tick(); tick();
        check("rst1_txd", txd, 1);
        check("rst1_iready", iready, 1);
        check("rst1_busy", busy, 0);
        check("rst1_ferr", frame_err, 0);
        reset = 1'b0;
        tick();
        check("rst1_post_txd", txd, 1);
        check("rst1_post_busy", busy, 0);

        // 2: single frame into an idle block
        send(10'h286);
        check("single_e0_txd", txd, 1);
        check("single_e0_busy", busy, 1);
        tick();
        check("single_e1_txd", txd, 1);
        tick();
        check("single_e2_txd", txd, 0);
        expect_frame(10'h286, 0, "single_bits");
        check("single_end_txd", txd, 1);
        check("single_end_busy", busy, 0);

        // 3: fill the FIFO with ivalid held high
        for (int cyc = 0; cyc < 6; cyc++) begin
            check($sformatf("fill_iready_c%0d", cyc), iready, (cyc < 5) ? 1 : 0);
            inputData = fill_fr[(cyc < 5) ? cyc : 4];
            ivalid    = 1'b1;
            tick();
        end
        ivalid = 1'b0;
        check("fill_iready_held", iready, 0);
        expect_frame(fill_fr[0], 3, "fill_f0");
        check("fill_iready_back", iready, 1);
        check("fill_gap0", txd, 1);
        tick();
        for (int k = 1; k < 5; k++) begin
            expect_frame(fill_fr[k], 0, $sformatf("fill_f%0d", k));
            check($sformatf("fill_gap%0d", k), txd, 1);
            if (k < 4) tick();
        end
        check("fill_end_busy", busy, 0);

        // 4: malformed frames are flagged and dropped
        send(10'h000);
        check("bad0_ferr", frame_err, 1);
        check("bad0_busy", busy, 0);
        tick();
        check("bad0_ferr_clear", frame_err, 0);
        send(10'h087);
        check("bad1_ferr", frame_err, 1);
        tick();
        check("bad1_ferr_clear", frame_err, 0);
        repeat (5) tick();
        check("bad_txd_idle", txd, 1);
        check("bad_busy", busy, 0);

        // 5: back-to-back frames with exactly one idle-high cycle between
        send(10'h2C2);
        send(10'h284);
        check("b2b_e1_txd", txd, 1);
        tick();
        expect_frame(10'h2C2, 0, "b2b_a");
        check("b2b_gap", txd, 1);
        tick();
        expect_frame(10'h284, 0, "b2b_B");
        check("b2b_end_busy", busy, 0);

        // 6: reset at bit 5 with three frames queued
        send(10'h286);
        send(10'h2C2);
        send(10'h284);
        send(10'h2A0);
        check("q_start_txd", txd, 0);
        repeat (2200) tick();
        check("q_bit5_txd", txd, 0);
        reset = 1'b1;
        tick();
        check("q_rst_txd", txd, 1);
        check("q_rst_busy", busy, 0);
        check("q_rst_iready", iready, 1);
        reset = 1'b0;
        begin
            int lows = 0;
            for (int c = 0; c < 5000; c++) begin
                if (txd !== 1'b1) lows++;
                tick();
            end
            check("q_no_tx", lows, 0);
        end
        check("q_end_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
